// File: rtl/sirv_rf_wr_arb_pkg.sv
// Shared definitions for the register-bank write-port scheduler.
package sirv_rf_wr_arb_pkg;

    // Requester identity: EXU is requester 0, LSU is requester 1
    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    localparam int unsigned DEF_DW   = 32;
    localparam int unsigned DEF_NREG = 32;
    localparam int unsigned DEF_AW   = 5;

    // Entry 0 reads as constant zero; writes and reservations to it are dropped
    localparam int unsigned ZERO_IDX = 0;

endpackage

// File: rtl/sirv_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, pointer is registered.
module sirv_rr_arb2
    import sirv_rf_wr_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] vld,
    output logic [1:0] gnt
);

    req_id_e rr_ptr;

    // One-hot grant: lone requester wins, contention resolved by rr_ptr, nothing during reset
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (vld)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_ptr == REQ_LSU) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Priority flips to the other requester after every grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= REQ_EXU;
        end else if (|gnt) begin
            rr_ptr <= gnt[1] ? REQ_EXU : REQ_LSU;
        end
    end

endmodule

// File: rtl/sirv_rf_wr_arb.sv
// Write-port scheduler: arbitrates EXU/LSU writebacks onto the bank's single
// write path and tracks in-flight destinations in a pending-write scoreboard.
module sirv_rf_wr_arb
    import sirv_rf_wr_arb_pkg::*;
#(
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned NREG = DEF_NREG,
    parameter int unsigned AW   = DEF_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_vld,
    output logic            req0_rdy,
    input  logic [AW-1:0]   req0_idx,
    input  logic [DW-1:0]   req0_dat,
    input  logic            req1_vld,
    output logic            req1_rdy,
    input  logic [AW-1:0]   req1_idx,
    input  logic [DW-1:0]   req1_dat,
    input  logic            rsv_vld,
    input  logic [AW-1:0]   rsv_idx,
    output logic [NREG-1:0] sb_busy,
    output logic [NREG-1:0] lden,
    output logic [DW-1:0]   dnxt
);

    logic [1:0]      gnt;
    logic            any_gnt;
    logic [AW-1:0]   win_idx;
    logic [DW-1:0]   win_dat;
    logic            wr_en;
    logic            rsv_en;
    logic [NREG-1:0] sb_set;
    logic [NREG-1:0] sb_nxt;

    // True for indices that map to a real, writable entry
    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return (32'(idx) != ZERO_IDX) && (32'(idx) < NREG);
    endfunction

    sirv_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .vld ({req1_vld, req0_vld}),
        .gnt (gnt)
    );

    assign req0_rdy = gnt[0];
    assign req1_rdy = gnt[1];
    assign any_gnt  = |gnt;

    // Winner's index/data mux and one-hot load-enable decode
    always_comb begin
        win_idx = gnt[1] ? req1_idx : req0_idx;
        win_dat = gnt[1] ? req1_dat : req0_dat;
        wr_en   = any_gnt && idx_ok(win_idx);
        lden    = wr_en ? (NREG'(1) << win_idx) : '0;
        dnxt    = any_gnt ? win_dat : '0;
    end

    // Scoreboard next state: completed writes clear, reservations set and win on a tie
    always_comb begin
        rsv_en = rsv_vld && idx_ok(rsv_idx);
        sb_set = rsv_en ? (NREG'(1) << rsv_idx) : '0;
        sb_nxt = (sb_busy & ~lden) | sb_set;
    end

    // Pending-write scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_busy <= '0;
        end else begin
            sb_busy <= sb_nxt;
        end
    end

endmodule
